// File: rtl/vector_pin_sequencer.sv
// Purpose : per-pin test-vector playback; drives tristate FORCE_I/FORCE_EN_BAR, strobes PIN_IN, compares masked expects.
// Latency : vector k is on the pins the cycle after START (k=0) or after vector k-1 ends; compare uses PIN_IN from 2 cycles earlier.
// Backpress: LOAD_READY low while running or when the buffer holds DEPTH vectors; START ignored while running.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   LOAD_VALID/LOAD_READY     vector write handshake (DRIVE, EN_BAR, EXPECT, MASK written at index count)
//   CLR_BUF                   empty the vector buffer (honoured only outside playback)
//   START, PERIOD, STROBE     begin playback; PERIOD = cycles per vector minus 1, STROBE = compare point
//   FORCE_I, FORCE_EN_BAR     registered per-pin drive value / drive disable (1 = released)
//   PIN_IN                    raw, asynchronous DUT pin levels
//   BUSY, DONE, FAIL          run status
//   FAIL_COUNT                saturating count of failing vectors
//   FIRST_FAIL_IDX            index of the first failing vector of the run
module vector_pin_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int PW    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] LOAD_DRIVE,
    input  logic [WIDTH-1:0] LOAD_EN_BAR,
    input  logic [WIDTH-1:0] LOAD_EXPECT,
    input  logic [WIDTH-1:0] LOAD_MASK,
    input  logic             CLR_BUF,
    input  logic             START,
    input  logic [PW-1:0]    PERIOD,
    input  logic [PW-1:0]    STROBE,
    output logic [WIDTH-1:0] FORCE_I,
    output logic [WIDTH-1:0] FORCE_EN_BAR,
    input  logic [WIDTH-1:0] PIN_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [15:0]      FAIL_COUNT,
    output logic [AW-1:0]    FIRST_FAIL_IDX
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One buffer entry: what to drive and what to expect back.
    typedef struct packed {
        logic [WIDTH-1:0] drive;
        logic [WIDTH-1:0] en_bar;
        logic [WIDTH-1:0] exp_val;
        logic [WIDTH-1:0] mask;
    } vec_t;

    localparam logic [AW:0]  CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    vec_t             vec_mem [DEPTH];
    state_t           state;
    logic [AW:0]      count;      // number of valid entries, 0..DEPTH
    logic [AW-1:0]    idx;        // vector currently on the pins
    logic [PW-1:0]    cnt;        // cycle within the current vector period
    logic [PW-1:0]    period_q;
    logic [PW-1:0]    strobe_q;   // already clamped to period_q
    logic [WIDTH-1:0] pin_meta;
    logic [WIDTH-1:0] pin_sync;

    logic             load_fire;
    logic             buf_empty;
    logic             at_strobe;
    logic             at_end;
    logic             last_vec;
    vec_t             cur_vec;
    vec_t             nxt_vec;
    vec_t             first_vec;
    logic [WIDTH-1:0] mismatch;

    // DEPTH is a power of two, so count[AW] set means the buffer is full.
    assign LOAD_READY = (state != ST_RUN) && !count[AW];
    assign load_fire  = LOAD_VALID && LOAD_READY;

    // A clear in the same cycle as START means the run sees an empty buffer.
    assign buf_empty  = CLR_BUF || (count == '0);

    assign cur_vec    = vec_mem[idx];
    assign nxt_vec    = vec_mem[idx + IDX_ONE];
    assign first_vec  = vec_mem[0];
    assign mismatch   = (pin_sync ^ cur_vec.exp_val) & cur_vec.mask;
    assign at_strobe  = (cnt == strobe_q);
    assign at_end     = (cnt == period_q);
    assign last_vec   = (({1'b0, idx} + CNT_ONE) == count);

    // Vector storage carries no reset: only entries below count are ever read.
    always_ff @(posedge CLK) begin
        if (load_fire && !CLR_BUF) begin
            vec_mem[count[AW-1:0]] <= '{drive:   LOAD_DRIVE,
                                        en_bar:  LOAD_EN_BAR,
                                        exp_val: LOAD_EXPECT,
                                        mask:    LOAD_MASK};
        end
    end

    // Two-flop synchronizer for the asynchronous pin levels.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pin_meta <= '0;
            pin_sync <= '0;
        end else begin
            pin_meta <= PIN_IN;
            pin_sync <= pin_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= ST_IDLE;
            count          <= '0;
            idx            <= '0;
            cnt            <= '0;
            period_q       <= '0;
            strobe_q       <= '0;
            FORCE_I        <= '0;
            FORCE_EN_BAR   <= '1;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            FAIL           <= 1'b0;
            FAIL_COUNT     <= '0;
            FIRST_FAIL_IDX <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (CLR_BUF) begin
                        count <= '0;
                    end else if (load_fire) begin
                        count <= count + CNT_ONE;
                    end

                    if (START) begin
                        period_q       <= PERIOD;
                        strobe_q       <= (STROBE > PERIOD) ? PERIOD : STROBE;
                        FAIL           <= 1'b0;
                        FAIL_COUNT     <= '0;
                        FIRST_FAIL_IDX <= '0;
                        idx            <= '0;
                        cnt            <= '0;
                        if (buf_empty) begin
                            // Nothing to play: report an immediate pass.
                            state <= ST_DONE;
                            DONE  <= 1'b1;
                        end else begin
                            state        <= ST_RUN;
                            DONE         <= 1'b0;
                            BUSY         <= 1'b1;
                            FORCE_I      <= first_vec.drive;
                            FORCE_EN_BAR <= first_vec.en_bar;
                        end
                    end
                end

                ST_RUN: begin
                    if (at_strobe && (mismatch != '0)) begin
                        if (FAIL_COUNT != 16'hFFFF) begin
                            FAIL_COUNT <= FAIL_COUNT + 16'd1;
                        end
                        if (!FAIL) begin
                            FIRST_FAIL_IDX <= idx;
                        end
                        FAIL <= 1'b1;
                    end

                    if (at_end) begin
                        cnt <= '0;
                        if (last_vec) begin
                            // Release every pin as soon as the last vector ends.
                            state        <= ST_DONE;
                            BUSY         <= 1'b0;
                            DONE         <= 1'b1;
                            FORCE_I      <= '0;
                            FORCE_EN_BAR <= '1;
                        end else begin
                            idx          <= idx + IDX_ONE;
                            FORCE_I      <= nxt_vec.drive;
                            FORCE_EN_BAR <= nxt_vec.en_bar;
                        end
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    BUSY         <= 1'b0;
                    DONE         <= 1'b0;
                    FORCE_I      <= '0;
                    FORCE_EN_BAR <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_pin_sequencer.sv
// Purpose : self-checking bench for vector_pin_sequencer (directed table rows, hand sequences, random runs).
// Latency : model predicts pin drive per cycle and results from per-edge PIN_IN history.
// Backpress: load attempts are checked against the model's free-slot prediction.
module tb_vector_pin_sequencer;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int PW = 8;
    localparam int HMASK = 16383;

    logic          CLK = 1'b0;
    logic          RST;
    logic          LOAD_VALID;
    logic          LOAD_READY;
    logic [W-1:0]  LOAD_DRIVE, LOAD_EN_BAR, LOAD_EXPECT, LOAD_MASK;
    logic          CLR_BUF, START;
    logic [PW-1:0] PERIOD, STROBE;
    logic [W-1:0]  FORCE_I, FORCE_EN_BAR, PIN_IN;
    logic          BUSY, DONE, FAIL;
    logic [15:0]   FAIL_COUNT;
    logic [AW-1:0] FIRST_FAIL_IDX;

    logic [W-1:0]  pin_rand = '0;
    int            pin_mode = 0;   // 0 loopback, 1 loopback with 0x22 stuck at 0x20, 2 random

    int checks = 0;
    int failures = 0;

    // Model state: buffer contents and PIN_IN seen just before each rising edge.
    logic [W-1:0] m_drive [D];
    logic [W-1:0] m_en    [D];
    logic [W-1:0] m_exp   [D];
    logic [W-1:0] m_mask  [D];
    int           m_n = 0;
    logic [W-1:0] hist [HMASK+1];
    int           edge_cnt = 0;

    assign PIN_IN = (pin_mode == 0) ? FORCE_I :
                    (pin_mode == 1) ? ((FORCE_I == 8'h22) ? 8'h20 : FORCE_I) :
                    pin_rand;

    vector_pin_sequencer #(.WIDTH(W), .DEPTH(D), .AW(AW), .PW(PW)) dut (
        .CLK(CLK), .RST(RST),
        .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
        .LOAD_DRIVE(LOAD_DRIVE), .LOAD_EN_BAR(LOAD_EN_BAR),
        .LOAD_EXPECT(LOAD_EXPECT), .LOAD_MASK(LOAD_MASK),
        .CLR_BUF(CLR_BUF), .START(START), .PERIOD(PERIOD), .STROBE(STROBE),
        .FORCE_I(FORCE_I), .FORCE_EN_BAR(FORCE_EN_BAR), .PIN_IN(PIN_IN),
        .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
        .FAIL_COUNT(FAIL_COUNT), .FIRST_FAIL_IDX(FIRST_FAIL_IDX)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt++;

    always @(negedge CLK) begin
        pin_rand = 8'($urandom);
        #2;
        hist[edge_cnt & HMASK] = PIN_IN;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_vec(input logic [W-1:0] dr, input logic [W-1:0] en,
                            input logic [W-1:0] ex, input logic [W-1:0] mk);
        chk("load_ready", {31'd0, LOAD_READY}, (m_n < D) ? 1 : 0);
        LOAD_VALID = 1'b1; LOAD_DRIVE = dr; LOAD_EN_BAR = en; LOAD_EXPECT = ex; LOAD_MASK = mk;
        if (m_n < D) begin
            m_drive[m_n] = dr; m_en[m_n] = en; m_exp[m_n] = ex; m_mask[m_n] = mk;
            m_n++;
        end
        @(negedge CLK);
        LOAD_VALID = 1'b0;
    endtask

    task automatic clear_buf();
        CLR_BUF = 1'b1;
        @(negedge CLK);
        CLR_BUF = 1'b0;
        m_n = 0;
    endtask

    // Plays the model buffer and checks every cycle; returns edges from START acceptance to DONE inclusive.
    task automatic do_run(input logic [PW-1:0] p, input logic [PW-1:0] s, input bit poke, output int cyc);
        int s_edge, span, eff, total, e, xc, xfirst;
        bit xf;
        logic [W-1:0] cmp;
        span  = int'(p) + 1;
        eff   = (s > p) ? int'(p) : int'(s);
        total = m_n * span;
        cyc   = -1;
        PERIOD = p; STROBE = s;
        START  = 1'b1;
        s_edge = edge_cnt;
        @(negedge CLK);
        START = 1'b0;
        for (int m = 0; m <= total; m++) begin
            if (DONE === 1'b1 && cyc < 0) cyc = m + 1;
            if (m < total) begin
                chk("run_busy", {31'd0, BUSY}, 1);
                chk("run_done", {31'd0, DONE}, 0);
                chk("run_force_i", {24'd0, FORCE_I}, {24'd0, m_drive[m / span]});
                chk("run_force_en_bar", {24'd0, FORCE_EN_BAR}, {24'd0, m_en[m / span]});
                START = poke && (m == 1);
                @(negedge CLK);
                START = 1'b0;
            end else begin
                chk("end_done", {31'd0, DONE}, 1);
                chk("end_busy", {31'd0, BUSY}, 0);
                chk("end_en_bar", {24'd0, FORCE_EN_BAR}, 32'hFF);
                chk("end_force_i", {24'd0, FORCE_I}, 0);
            end
        end
        xf = 1'b0; xc = 0; xfirst = 0;
        for (int k = 0; k < m_n; k++) begin
            e   = s_edge + k * span + eff + 1;
            cmp = (hist[(e - 2) & HMASK] ^ m_exp[k]) & m_mask[k];
            if (cmp != '0) begin
                if (!xf) xfirst = k;
                xf = 1'b1;
                xc++;
            end
        end
        chk("res_fail", {31'd0, FAIL}, {31'd0, xf});
        chk("res_fail_count", {16'd0, FAIL_COUNT}, xc);
        chk("res_first_idx", {28'd0, FIRST_FAIL_IDX}, xfirst);
    endtask

    typedef struct {
        int          n;
        logic [7:0]  p;
        logic [7:0]  s;
        int          pmode;
        bit          mask2;
        bit          poke;
        bit          exp_fail;
        int          exp_cnt;
        int          exp_first;
        int          exp_cyc;
    } row_t;

    row_t rows [4];

    initial begin
        int cyc;
        logic [W-1:0] dr, ex, mk;
        logic [PW-1:0] rp, rs;

        rows[0] = '{3, 8'd3, 8'd2, 0, 1'b0, 1'b0, 1'b0, 0, 0, 13};
        rows[1] = '{3, 8'd3, 8'd2, 1, 1'b1, 1'b0, 1'b1, 1, 1, 13};
        rows[2] = '{2, 8'd0, 8'd5, 0, 1'b0, 1'b1, 1'b1, 2, 0, 3};
        rows[3] = '{0, 8'd3, 8'd2, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1};

        RST = 1'b1; LOAD_VALID = 1'b0; CLR_BUF = 1'b0; START = 1'b0;
        LOAD_DRIVE = '0; LOAD_EN_BAR = '0; LOAD_EXPECT = '0; LOAD_MASK = '0;
        PERIOD = '0; STROBE = '0;
        repeat (2) @(negedge CLK);
        chk("rst_en_bar", {24'd0, FORCE_EN_BAR}, 32'hFF);
        chk("rst_force_i", {24'd0, FORCE_I}, 0);
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_done", {31'd0, DONE}, 0);
        chk("rst_fail", {31'd0, FAIL}, 0);
        chk("rst_fail_count", {16'd0, FAIL_COUNT}, 0);
        chk("rst_first_idx", {28'd0, FIRST_FAIL_IDX}, 0);
        chk("rst_load_ready", {31'd0, LOAD_READY}, 1);
        RST = 1'b0;
        @(negedge CLK);

        // Directed rows
        for (int r = 0; r < 4; r++) begin
            clear_buf();
            for (int i = 0; i < rows[r].n; i++) begin
                dr = 8'(8'h11 * (i + 1));
                ex = (rows[r].mask2 && i == 2) ? 8'h03 : dr;
                mk = (rows[r].mask2 && i == 2) ? 8'h0F : 8'hFF;
                load_vec(dr, 8'h00, ex, mk);
            end
            pin_mode = rows[r].pmode;
            repeat (2) @(negedge CLK);
            do_run(rows[r].p, rows[r].s, rows[r].poke, cyc);
            chk("row_done_cycles", cyc, rows[r].exp_cyc);
            chk("row_fail", {31'd0, FAIL}, {31'd0, rows[r].exp_fail});
            chk("row_fail_count", {16'd0, FAIL_COUNT}, rows[r].exp_cnt);
            chk("row_first_idx", {28'd0, FIRST_FAIL_IDX}, rows[r].exp_first);
        end

        // Fill to capacity, hold LOAD_VALID on a full buffer, replay, then clear in DONE
        pin_mode = 2;
        clear_buf();
        for (int i = 0; i < D + 1; i++) begin
            load_vec(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        chk("full_load_ready", {31'd0, LOAD_READY}, 0);
        LOAD_VALID = 1'b1; LOAD_DRIVE = 8'hA5; LOAD_EN_BAR = 8'h5A;
        repeat (3) @(negedge CLK);
        LOAD_VALID = 1'b0;
        chk("full_held_ready", {31'd0, LOAD_READY}, 0);
        do_run(8'd0, 8'd0, 1'b0, cyc);
        chk("full_done_cycles", cyc, D + 1);
        clear_buf();
        chk("clr_load_ready", {31'd0, LOAD_READY}, 1);
        do_run(8'd2, 8'd1, 1'b0, cyc);
        chk("clr_empty_cycles", cyc, 1);

        // Reset in the middle of a run
        pin_mode = 0;
        for (int i = 0; i < 4; i++) load_vec(8'h0F, 8'h00, 8'h0F, 8'hFF);
        PERIOD = 8'd3; STROBE = 8'd1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_busy", {31'd0, BUSY}, 1);
        chk("mid_en_bar", {24'd0, FORCE_EN_BAR}, 0);
        RST = 1'b1;
        #1;
        chk("arst_en_bar", {24'd0, FORCE_EN_BAR}, 32'hFF);
        chk("arst_force_i", {24'd0, FORCE_I}, 0);
        chk("arst_busy", {31'd0, BUSY}, 0);
        chk("arst_done", {31'd0, DONE}, 0);
        chk("arst_load_ready", {31'd0, LOAD_READY}, 1);
        @(negedge CLK);
        RST = 1'b0;
        m_n = 0;
        @(negedge CLK);
        do_run(8'd1, 8'd0, 1'b0, cyc);
        chk("arst_empty_cycles", cyc, 1);

        // Randomized runs, some replaying the retained buffer
        for (int it = 0; it < 25; it++) begin
            pin_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
            if (m_n == 0 || $urandom_range(0, 3) != 0) begin
                clear_buf();
                for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                    load_vec(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                end
            end
            rp = 8'($urandom_range(0, 4));
            rs = 8'($urandom_range(0, 6));
            @(negedge CLK);
            do_run(rp, rs, 1'($urandom_range(0, 1)), cyc);
            chk("rnd_done_cycles", cyc, m_n * (int'(rp) + 1) + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
